// File: rtl/ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// ps2_scancode_decoder
//
// Receives PS/2 device-to-host frames (start, 8 data bits LSB first, odd
// parity, stop) and turns the byte stream into key events. E0 (extended) and
// F0 (break) prefixes are absorbed into flags, and every other good byte is
// reported as one event carrying the scan code, a make/break flag and an
// extended flag. All logic runs on clk_50. PS2_CLK and PS2_DAT are
// asynchronous to it.
//
// Optional feature (compile-time macro PS2_TIMEOUT_EN):
//   When this macro is defined, a mid-frame watchdog is built. A frame that
//   stalls for TIMEOUT_CYCLES clk_50 cycles is aborted and reported on
//   frame_err. When it is not defined, no counter is built and a truncated
//   frame waits until the next reset.
//
// Parameters:
//   SYNC_STAGES     synchroniser depth for PS2_CLK / PS2_DAT (>= 2)
//   FILTER_LEN      consecutive disagreeing samples before the filtered clock moves
//   TIMEOUT_CYCLES  watchdog limit (used only with PS2_TIMEOUT_EN)
//
// Ports:
//   clk_50      in   system clock
//   rst_n       in   synchronous reset, active low
//   PS2_CLK     in   PS/2 clock line (async, idle high)
//   PS2_DAT     in   PS/2 data line (async, idle high)
//   code_valid  out  one-cycle pulse, new key event on code_*
//   code_out    out  scan code with prefixes removed, held between events
//   code_make   out  1 = press, 0 = release, held with code_out
//   code_ext    out  1 = event was E0-prefixed, held with code_out
//   frame_err   out  one-cycle pulse on bad parity, bad stop bit or timeout
// ---------------------------------------------------------------------------
module ps2_scancode_decoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50,
    input  logic       rst_n,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       code_valid,
    output logic [7:0] code_out,
    output logic       code_make,
    output logic       code_ext,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam logic [FW-1:0] FILT_MAX = FW'(FILTER_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    // Illegal parameter values are rejected when the design is elaborated.
    if (SYNC_STAGES < 2 || FILTER_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ps2_scancode_decoder: illegal parameter value");
    end

    // ------------------------------------------------------------------
    // Input synchronisers and clock glitch filter
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic                   filt_clk_q, filt_clk_d;
    logic [FW-1:0]          filt_cnt_q, filt_cnt_d;
    logic                   clk_s, dat_s, strobe;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dat_s = dat_sync_q[SYNC_STAGES-1];

    // NOTE: every combinational output gets a default before any branch.
    // Without that default, a path that skips an assignment would infer a latch.
    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], PS2_CLK};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], PS2_DAT};
        filt_clk_d = filt_clk_q;
        filt_cnt_d = '0;
        // Any agreeing sample restarts the run, so a glitch shorter than
        // FILTER_LEN samples never moves the filtered clock.
        if (clk_s != filt_clk_q) begin
            if (filt_cnt_q == FILT_MAX) begin
                filt_clk_d = clk_s;
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
    end

    // The host samples data on the falling edge of the filtered clock.
    assign strobe = filt_clk_q & ~filt_clk_d;

    // ------------------------------------------------------------------
    // Optional mid-frame watchdog
    // ------------------------------------------------------------------
    state_e state_q, state_d;
    logic   timeout;

`ifdef PS2_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        timeout  = 1'b0;
        if (state_q == S_IDLE || strobe) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_MAX) begin
            // The counter saturates at TO_MAX, so an abort fires only once.
            to_cnt_d = to_cnt_q + TO_W'(1);
            timeout  = (to_cnt_d == TO_MAX);
        end
    end

    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Frame FSM and prefix decoder
    // ------------------------------------------------------------------
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       par_q, par_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic       code_valid_q, code_valid_d;
    logic [7:0] code_out_q, code_out_d;
    logic       code_make_q, code_make_d;
    logic       code_ext_q, code_ext_d;
    logic       frame_err_q, frame_err_d;
    logic       frame_ok;

    // The XOR over the data and parity bits is 1 when parity is odd.
    // The stop bit is the line value at the current strobe.
    assign frame_ok = (^{shift_q, par_q}) & dat_s;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        par_d        = par_q;
        ext_d        = ext_q;
        brk_d        = brk_q;
        code_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        code_out_d   = code_out_q;
        code_make_d  = code_make_q;
        code_ext_d   = code_ext_q;

        if (strobe) begin
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_s) begin
                        state_d   = S_DATA;
                        bit_cnt_d = '0;
                    end
                end
                S_DATA: begin
                    shift_d = {dat_s, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                S_PARITY: begin
                    par_d   = dat_s;
                    state_d = S_STOP;
                end
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!frame_ok) begin
                        frame_err_d = 1'b1;
                        ext_d       = 1'b0;
                        brk_d       = 1'b0;
                    end else if (shift_q == 8'hE0) begin
                        ext_d = 1'b1;
                    end else if (shift_q == 8'hF0) begin
                        brk_d = 1'b1;
                    end else begin
                        code_valid_d = 1'b1;
                        code_out_d   = shift_q;
                        code_make_d  = ~brk_q;
                        code_ext_d   = ext_q;
                        ext_d        = 1'b0;
                        brk_d        = 1'b0;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // A timeout happens only in a cycle with no strobe. So it never
        // collides with the pulse that a completed frame produces.
        if (timeout) begin
            state_d     = S_IDLE;
            frame_err_d = 1'b1;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
        end
    end

    // NOTE: sequential state updates use non-blocking assignments only. Every
    // flop then samples the values from before the edge, whatever the statement order.
    always_ff @(posedge clk_50) begin
        if (!rst_n) begin
            clk_sync_q   <= '1;
            dat_sync_q   <= '1;
            filt_clk_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= S_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            ext_q        <= 1'b0;
            brk_q        <= 1'b0;
            code_valid_q <= 1'b0;
            code_out_q   <= '0;
            code_make_q  <= 1'b0;
            code_ext_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            dat_sync_q   <= dat_sync_d;
            filt_clk_q   <= filt_clk_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            ext_q        <= ext_d;
            brk_q        <= brk_d;
            code_valid_q <= code_valid_d;
            code_out_q   <= code_out_d;
            code_make_q  <= code_make_d;
            code_ext_q   <= code_ext_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign code_valid = code_valid_q;
    assign code_out   = code_out_q;
    assign code_make  = code_make_q;
    assign code_ext   = code_ext_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_scancode_decoder
//
// Directed bench for ps2_scancode_decoder. The stimulus tasks drive PS/2
// frames and push the expected events into a scoreboard queue. A monitor on
// the falling edge of clk_50 pops one entry per output pulse and compares it.
// The monitor also checks that code_* never change without code_valid. The
// PS/2 bit period is compressed to 2*HALF clk_50 cycles to keep runs short.
// ---------------------------------------------------------------------------
module tb_ps2_scancode_decoder;

    localparam int SYNC = 2;
    localparam int FILT = 8;
    localparam int HALF = 20;
`ifdef PS2_TIMEOUT_EN
    localparam int TO = 300;
`else
    localparam int TO = 50000;
`endif

    logic       clk_50 = 1'b0;
    logic       rst_n = 1'b0;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic       code_valid;
    logic [7:0] code_out;
    logic       code_make;
    logic       code_ext;
    logic       frame_err;

    ps2_scancode_decoder #(
        .SYNC_STAGES   (SYNC),
        .FILTER_LEN    (FILT),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_50    (clk_50),
        .rst_n     (rst_n),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .code_valid(code_valid),
        .code_out  (code_out),
        .code_make (code_make),
        .code_ext  (code_ext),
        .frame_err (frame_err)
    );

    always #10 clk_50 = ~clk_50;

    int unsigned cyc = 0;
    always @(posedge clk_50) cyc <= cyc + 1;

    typedef struct {
        bit         is_err;
        logic [7:0] code;
        bit         make;
        bit         ext;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          n_pushed = 0;
    int          n_pulses = 0;
    int unsigned fall_cyc = 0;
    int unsigned pulse_cyc = 0;
    int          lat = 0;
    bit          mon_en = 1'b0;
    bit          hold_skip = 1'b0;
    logic [7:0]  hold_code = '0;
    logic        hold_make = 1'b0;
    logic        hold_ext = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_code(input logic [7:0] c, input bit mk, input bit ex);
        exp_t e;
        e.is_err = 1'b0;
        e.code   = c;
        e.make   = mk;
        e.ext    = ex;
        sb.push_back(e);
        n_pushed++;
    endtask

    task automatic push_err();
        exp_t e;
        e.is_err = 1'b1;
        e.code   = '0;
        e.make   = 1'b0;
        e.ext    = 1'b0;
        sb.push_back(e);
        n_pushed++;
    endtask

    // The device changes data while PS2_CLK is high. The host samples on the fall.
    task automatic drive_bit(input bit d);
        @(posedge clk_50); #1;
        PS2_DAT = d;
        repeat (HALF) @(posedge clk_50);
        #1;
        PS2_CLK  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(posedge clk_50);
        #1;
        PS2_CLK = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit((~^b) ^ bad_par);
        drive_bit(stop);
        PS2_DAT = 1'b1;
        repeat (3 * HALF) @(posedge clk_50);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(posedge clk_50);
        check(tag, sb.size(), 0);
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk_50) begin
        if (mon_en) begin
            if (code_valid || frame_err) begin
                exp_t e;
                n_pulses++;
                pulse_cyc = cyc;
                check("valid_err_exclusive", {code_valid, frame_err} != 2'b11, 1);
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_pulse: observed valid=%0b err=%0b code=0x%0h expected no pulse",
                           code_valid, frame_err, code_out);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("pulse_is_err", frame_err, e.is_err);
                    if (!e.is_err) begin
                        check("code_out", code_out, e.code);
                        check("code_make", code_make, e.make);
                        check("code_ext", code_ext, e.ext);
                    end
                end
                if (code_valid) begin
                    hold_code = code_out;
                    hold_make = code_make;
                    hold_ext  = code_ext;
                end
            end else if (hold_skip) begin
                hold_code = code_out;
                hold_make = code_make;
                hold_ext  = code_ext;
            end else begin
                check("hold_code_out", code_out, hold_code);
                check("hold_make_ext", {code_make, code_ext}, {hold_make, hold_ext});
            end
        end
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (4) @(posedge clk_50);
        @(negedge clk_50);
        check("reset_outputs", {code_valid, code_out, code_make, code_ext, frame_err}, '0);
        @(posedge clk_50); #1;
        rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk_50);

        // Plain make code 0x75; calibrate the latency from the last fall to the pulse
        push_code(8'h75, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("t1_drained", 200);
        lat = int'(pulse_cyc - fall_cyc);
        check("t1_latency_range", (lat >= SYNC + FILT - 1) && (lat <= SYNC + FILT + 4), 1);

        // Extended break: E0 F0 74
        push_code(8'h74, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h74, 1'b0, 1'b1);
        drain("t2_drained", 200);

        // Parity error clears brk: F0, bad 6B, 72
        send_frame(8'hF0, 1'b0, 1'b1);
        push_err();
        send_frame(8'h6B, 1'b1, 1'b1);
        push_code(8'h72, 1'b1, 1'b0);
        send_frame(8'h72, 1'b0, 1'b1);
        drain("t3_drained", 200);

        // Stop-bit error clears ext: E0, 75 with stop 0, then 75
        send_frame(8'hE0, 1'b0, 1'b1);
        push_err();
        send_frame(8'h75, 1'b0, 1'b0);
        push_code(8'h75, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("stop_err_drained", 200);

        // Non-prefix bytes pass through, including AA and E1
        push_code(8'hAA, 1'b1, 1'b0);
        send_frame(8'hAA, 1'b0, 1'b1);
        push_code(8'hE1, 1'b0, 1'b1);
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'hE1, 1'b0, 1'b1);
        drain("passthru_drained", 200);

        // A 7-cycle clock glitch with data low must not start a frame
        @(posedge clk_50); #1;
        PS2_DAT = 1'b0;
        PS2_CLK = 1'b0;
        repeat (FILT - 1) @(posedge clk_50);
        #1;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (2 * HALF) @(posedge clk_50);
        push_code(8'h75, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("t4_drained", 200);

`ifdef PS2_TIMEOUT_EN
        // Truncated frame: start + 4 bits, then the lines stay idle
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
        PS2_DAT = 1'b1;
        push_err();
        drain("t5_timeout_drained", TO + 200);
        check("t5_timeout_latency", int'(pulse_cyc - fall_cyc), lat + TO);
        push_code(8'h75, 1'b1, 1'b0);
        send_frame(8'h75, 1'b0, 1'b1);
        drain("t5_recover_drained", 200);
`endif

        // Reset mid-frame after the 5th data bit of 0x72
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(((8'h72 >> i) & 8'h01) != 0);
        hold_skip = 1'b1;
        @(posedge clk_50); #1;
        rst_n = 1'b0;
        @(posedge clk_50); #1;
        rst_n = 1'b1;
        PS2_DAT = 1'b1;
        @(negedge clk_50);
        check("t6_reset_outputs", {code_valid, code_out, code_make, code_ext, frame_err}, '0);
        repeat (3) @(posedge clk_50);
        hold_skip = 1'b0;
        repeat (2 * HALF) @(posedge clk_50);
        push_code(8'h6B, 1'b1, 1'b0);
        send_frame(8'h6B, 1'b0, 1'b1);
        drain("t6_drained", 200);

        repeat (100) @(posedge clk_50);
        check("total_pulses", n_pulses, n_pushed);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
